// File: rtl/uart_pkg.sv
// Shared types for the buffered UART receive path.
// Holds the capture FSM state encoding and the default FIFO depth.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      WAIT = 2'd2
   } cap_state_t;

   localparam int UART_RX_BUF_DEPTH_DEF = 8;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with first-word-fall-through head and explicit occupancy count.
// Storage is not reset; pointers and count are.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_RX_BUF_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [7:0]               i_din,
   input  logic                     i_pop,
   output logic [7:0]               o_dout,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_pop;
   logic          w_push;

   // A pop frees a slot in the same edge, so a full FIFO can still accept.
   assign w_pop  = i_pop & (r_count != '0);
   assign w_push = i_push & ((r_count != L_DEPTH) | w_pop);

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == L_DEPTH);
   assign o_count = r_count;
   assign o_dout  = o_empty ? 8'h00 : r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_buf.sv
// UART receive buffer: one push per receiver rdy pulse, acked by clr_rdy.
// Define UART_RX_BUF_OVR_EN to enable the sticky overrun flag.
module uart_rx_buf
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_RX_BUF_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_rdy,
   input  logic [7:0]               rx_data,
   output logic                     clr_rdy,
   input  logic                     rd_en,
   output logic [7:0]               dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overrun,
   input  logic                     ovr_clr
);

   cap_state_t r_state;
   logic       r_clr_rdy;
   logic       w_push;
   logic       w_drop;

   assign w_push = (r_state == IDLE) & rx_rdy;
   // Full with a simultaneous pop still takes the byte.
   assign w_drop = w_push & full & ~rd_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_clr_rdy <= 1'b0;
      end else begin
         r_clr_rdy <= w_push;
         unique case (r_state)
            IDLE:    if (rx_rdy) r_state <= ACK;
            ACK:     r_state <= WAIT;
            WAIT:    if (!rx_rdy) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign clr_rdy = r_clr_rdy;

`ifdef UART_RX_BUF_OVR_EN
   logic r_overrun;

   always_ff @(posedge clk) begin
      if (rst)
         r_overrun <= 1'b0;
      else if (w_drop)
         r_overrun <= 1'b1;
      else if (ovr_clr)
         r_overrun <= 1'b0;
   end

   assign overrun = r_overrun;
`else
   logic w_unused_ovr;
   assign w_unused_ovr = ovr_clr ^ w_drop;
   assign overrun      = 1'b0;
`endif

   uart_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (rx_data),
      .i_pop   (rd_en),
      .o_dout  (dout),
      .o_empty (empty),
      .o_full  (full),
      .o_count (count)
   );

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf at DEPTH=8 and DEPTH=4.
// Honours UART_RX_BUF_OVR_EN for the expected overrun behaviour.
module tb_uart_rx_buf;

`ifdef UART_RX_BUF_OVR_EN
   localparam logic OVR_EXP = 1'b1;
`else
   localparam logic OVR_EXP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_rdy, rd_en, ovr_clr;
   logic [7:0] rx_data;
   logic       clr_rdy, empty, full, overrun;
   logic [7:0] dout;
   logic [3:0] count;

   logic       b_rx_rdy, b_rd_en;
   logic [7:0] b_rx_data;
   logic       b_clr_rdy, b_empty, b_full, b_overrun;
   logic [7:0] b_dout;
   logic [2:0] b_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] q[$];
   logic [7:0] v;

   always #5 clk = ~clk;

   uart_rx_buf #(.DEPTH(8)) dut_a (
      .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
      .clr_rdy(clr_rdy), .rd_en(rd_en), .dout(dout), .empty(empty),
      .full(full), .count(count), .overrun(overrun), .ovr_clr(ovr_clr)
   );

   uart_rx_buf #(.DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .rx_rdy(b_rx_rdy), .rx_data(b_rx_data),
      .clr_rdy(b_clr_rdy), .rd_en(b_rd_en), .dout(b_dout),
      .empty(b_empty), .full(b_full), .count(b_count),
      .overrun(b_overrun), .ovr_clr(1'b0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic a_send(input logic [7:0] d);
      rx_rdy  = 1'b1;
      rx_data = d;
      tick();
      chk("a_clr_pulse", clr_rdy, 1);
      rx_rdy = 1'b0;
      tick();
      chk("a_clr_low", clr_rdy, 0);
      tick();
   endtask

   task automatic a_pop(input logic [7:0] exp);
      chk("a_pop_dout", dout, exp);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic b_send(input logic [7:0] d);
      b_rx_rdy  = 1'b1;
      b_rx_data = d;
      tick();
      chk("b_clr_pulse", b_clr_rdy, 1);
      b_rx_rdy = 1'b0;
      tick();
      tick();
      q.push_back(d);
      chk("b_count_push", b_count, q.size());
   endtask

   task automatic b_pop();
      chk("b_pop_dout", b_dout, q[0]);
      void'(q.pop_front());
      b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      chk("b_count_pop", b_count, q.size());
   endtask

   initial begin
      rst = 1'b1; rx_rdy = 0; rd_en = 0; ovr_clr = 0; rx_data = 0;
      b_rx_rdy = 0; b_rd_en = 0; b_rx_data = 0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_clr", clr_rdy, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_dout", dout, 8'h00);

      // single byte held for three cycles
      rx_rdy = 1'b1; rx_data = 8'hA5;
      tick();
      chk("sb_clr1", clr_rdy, 1);
      chk("sb_count", count, 1);
      chk("sb_dout", dout, 8'hA5);
      chk("sb_empty", empty, 0);
      tick();
      chk("sb_clr2", clr_rdy, 0);
      tick();
      chk("sb_clr3", clr_rdy, 0);
      chk("sb_count3", count, 1);
      rx_rdy = 1'b0;
      tick();
      tick();
      chk("sb_count_end", count, 1);
      a_pop(8'hA5);
      chk("sb_empty_end", empty, 1);
      chk("sb_dout_end", dout, 8'h00);

      // fill
      for (int i = 1; i <= 8; i++) a_send(8'(i));
      chk("fill_full", full, 1);
      chk("fill_count", count, 8);
      chk("fill_head", dout, 8'h01);

      // drop on full
      a_send(8'hFF);
      chk("ovr_count", count, 8);
      chk("ovr_head", dout, 8'h01);
      chk("ovr_flag", overrun, OVR_EXP);
      tick();
      chk("ovr_sticky", overrun, OVR_EXP);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_cleared", overrun, 0);

      // push and pop together while full
      rx_rdy = 1'b1; rx_data = 8'h55; rd_en = 1'b1;
      tick();
      rx_rdy = 1'b0; rd_en = 1'b0;
      chk("sim_clr", clr_rdy, 1);
      chk("sim_count", count, 8);
      chk("sim_full", full, 1);
      chk("sim_head", dout, 8'h02);
      chk("sim_ovr", overrun, 0);
      tick();
      tick();
      for (int i = 2; i <= 8; i++) a_pop(8'(i));
      a_pop(8'h55);
      chk("drain_empty", empty, 1);
      chk("drain_dout", dout, 8'h00);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("empty_pop_count", count, 0);

      // push and pop together while empty
      rx_rdy = 1'b1; rx_data = 8'h77; rd_en = 1'b1;
      tick();
      rx_rdy = 1'b0; rd_en = 1'b0;
      chk("emp_sim_count", count, 1);
      chk("emp_sim_dout", dout, 8'h77);
      tick();
      tick();
      a_pop(8'h77);

      // reset in WAIT with rdy still high
      rx_rdy = 1'b1; rx_data = 8'h3C;
      tick();
      tick();
      chk("rw_pre_count", count, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rw_rst_count", count, 0);
      chk("rw_rst_clr", clr_rdy, 0);
      chk("rw_rst_dout", dout, 8'h00);
      tick();
      chk("rw_cap_count", count, 1);
      chk("rw_cap_clr", clr_rdy, 1);
      chk("rw_cap_dout", dout, 8'h3C);
      tick();
      tick();
      tick();
      chk("rw_once_count", count, 1);
      rx_rdy = 1'b0;
      tick();
      tick();
      chk("rw_final_count", count, 1);
      a_pop(8'h3C);

      // wrap at DEPTH=4
      b_send(8'hC0);
      b_send(8'hC1);
      for (int i = 0; i < 20; i++) begin
         v = 8'((i * 7 + 3) & 8'hFF);
         b_send(v);
         chk("b_count_max", 32'(b_count <= 3'd4), 1);
         b_pop();
      end
      while (q.size() > 0) b_pop();
      chk("b_empty", b_empty, 1);
      b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      chk("b_empty_pop", b_count, 0);
      chk("b_empty_dout", b_dout, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
